mc_ref_rd_arb: RTL and testbench
================================

MC_REF_RD_ARB -- requirements
Module: mc_ref_rd_arb

Interface
REQ-001 Parameter ADDR_W, default 7, requester-side reference-buffer row address width.
REQ-002 Parameter DATA_W, default 20*`BIT_DEPTH, read data width (one 20-pixel reference row).
REQ-003 clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 rst_i  input  1  synchronous reset, active-high.
REQ-005 luma_req_i  input  1  luma MC requests a read this cycle.
REQ-006 luma_addr_i  input  ADDR_W  luma row address.
REQ-007 luma_last_i  input  1  current luma request is the last row of its burst.
REQ-008 luma_gnt_o  output  1  luma owns the buffer port.
REQ-009 luma_rdack_o  output  1  luma read accepted this cycle.
REQ-010 chroma_req_i, chroma_addr_i, chroma_last_i, chroma_gnt_o, chroma_rdack_o: same directions, widths and meanings, for chroma MC.
REQ-011 mem_rden_o  output  1  read strobe to reference buffer.
REQ-012 mem_addr_o  output  ADDR_W+1  {region, row}; region 0 = luma, 1 = chroma.
REQ-013 mem_rdack_i  input  1  buffer accepted mem_rden_o this cycle.
REQ-014 mem_data_i  input  DATA_W  read data, valid the cycle after mem_rdack_i.
REQ-015 rd_data_o  output  DATA_W  mem_data_i registered once, broadcast to both requesters.
REQ-016 rd_valid_luma_o / rd_valid_chroma_o  output  1 each  rd_data_o valid for that requester.

Function
REQ-017 FSM states IDLE, LUMA, CHROMA; register last_owner (0 = luma, 1 = chroma).
REQ-018 IDLE: neither req -> stay; one req -> go to its state; both -> winner per REQ-030/031.
REQ-019 gnt outputs are registered decodes of state: luma_gnt_o = (state==LUMA), chroma_gnt_o = (state==CHROMA); first grant visible one cycle after request in IDLE.
REQ-020 mem_rden_o = owner's req_i while granted, else 0; mem_addr_o = {state==CHROMA, owner addr}; 0 when not granted.
REQ-021 owner rdack_o = mem_rdack_i & granted-to-it (combinational); the other rdack_o = 0.
REQ-022 Burst is non-preemptible: owner keeps grant until a cycle with owner req & last_i & mem_rdack_i (end-of-burst).
REQ-023 At end-of-burst: last_owner <= owner; next state re-arbitrated with the ended owner's current req ignored; other requests -> switch directly (zero-bubble); none -> IDLE.
REQ-024 Owner deasserts req mid-burst -> grant held, mem_rden_o = 0, no state change.
REQ-025 mem_rdack_i while mem_rden_o = 0 is ignored (no rdack_o, no valid).
REQ-026 rd_data_o <= mem_data_i every cycle; rd_valid_X_o <= X_rdack_o (one-cycle latency, registered).
REQ-027 rd_valid tag follows the owner at rdack time, so data of a burst's final row is tagged correctly even after grant switches.
REQ-028 Non-owner req held indefinitely: no effect until end-of-burst.

Reset
REQ-029 rst_i high on a clock edge: state = IDLE, last_owner = 1, all gnt/rdack/valid/mem_rden_o = 0, mem_addr_o = 0, rd_data_o = 0; mid-burst reset aborts burst, no pending valid issued after.

Configuration
REQ-030 Macro MC_ARB_LUMA_PRIO_EN defined: on simultaneous requests luma always wins; last_owner still updated but unused.
REQ-031 Macro MC_ARB_LUMA_PRIO_EN undefined: round-robin, simultaneous requests granted to requester != last_owner.

Verification
REQ-032 Reset, luma_req_i=1 addr=5, last=1, mem_rdack_i=1 -> luma_gnt_o=1 at cycle 1, mem_addr_o=0x005, luma_rdack_o=1, rd_valid_luma_o=1 next cycle, return to IDLE.
REQ-033 Both request continuously, 4-row bursts, round-robin build -> grants alternate luma,chroma,luma with no idle cycle between bursts; chroma mem_addr_o MSB=1.
REQ-034 Same stimulus with MC_ARB_LUMA_PRIO_EN -> luma holds every arbitration; chroma granted only when luma_req_i=0.
REQ-035 Chroma requests at row 2 of a 22-row luma burst -> chroma_gnt_o stays 0 until luma last row accepted, then 1 next cycle.
REQ-036 mem_rdack_i=0 for 3 cycles mid-burst -> mem_rden_o held, address unchanged, no rdack/valid pulses; resumes on ack.
REQ-037 rst_i asserted at row 7 of luma burst -> next cycle all outputs 0, state IDLE; following simultaneous requests grant luma first.

Source files
------------

// File: rtl/mc_ref_rd_arb.sv
// mc_ref_rd_arb: luma/chroma arbiter for the shared reference-buffer read port.
// Round-robin by default; MC_ARB_LUMA_PRIO_EN makes luma win simultaneous requests.
`ifndef BIT_DEPTH
`define BIT_DEPTH 8
`endif
module mc_ref_rd_arb #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 20*`BIT_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              luma_req_i,
  input  logic [ADDR_W-1:0] luma_addr_i,
  input  logic              luma_last_i,
  output logic              luma_gnt_o,
  output logic              luma_rdack_o,
  input  logic              chroma_req_i,
  input  logic [ADDR_W-1:0] chroma_addr_i,
  input  logic              chroma_last_i,
  output logic              chroma_gnt_o,
  output logic              chroma_rdack_o,
  output logic              mem_rden_o,
  output logic [ADDR_W:0]   mem_addr_o,
  input  logic              mem_rdack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_luma_o,
  output logic              rd_valid_chroma_o
);
  typedef enum logic [1:0] {IDLE, LUMA, CHROMA} state_t;
  state_t r_state, w_next, w_win;
  logic r_last_owner, w_luma_own, w_chroma_own, w_eob;
  assign w_luma_own     = r_state == LUMA;
  assign w_chroma_own   = r_state == CHROMA;
  assign luma_gnt_o     = w_luma_own;
  assign chroma_gnt_o   = w_chroma_own;
  assign mem_rden_o     = (w_luma_own & luma_req_i) | (w_chroma_own & chroma_req_i);
  assign mem_addr_o     = w_luma_own ? {1'b0, luma_addr_i} : w_chroma_own ? {1'b1, chroma_addr_i} : '0;
  assign luma_rdack_o   = mem_rdack_i & w_luma_own & luma_req_i;
  assign chroma_rdack_o = mem_rdack_i & w_chroma_own & chroma_req_i;
  assign w_eob          = (luma_rdack_o & luma_last_i) | (chroma_rdack_o & chroma_last_i);
`ifdef MC_ARB_LUMA_PRIO_EN
  assign w_win = LUMA;
`else
  assign w_win = r_last_owner ? LUMA : CHROMA;
`endif
  // the owner whose burst just ended is excluded, so a waiting requester switches in with no bubble
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE)
      w_next = (luma_req_i & chroma_req_i) ? w_win : luma_req_i ? LUMA : chroma_req_i ? CHROMA : IDLE;
    else if (w_eob)
      w_next = w_luma_own ? (chroma_req_i ? CHROMA : IDLE) : (luma_req_i ? LUMA : IDLE);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state           <= IDLE;
      r_last_owner      <= 1'b1;
      rd_data_o         <= '0;
      rd_valid_luma_o   <= 1'b0;
      rd_valid_chroma_o <= 1'b0;
    end else begin
      r_state           <= w_next;
      if (w_eob) r_last_owner <= w_chroma_own;
      rd_data_o         <= mem_data_i;
      rd_valid_luma_o   <= luma_rdack_o;
      rd_valid_chroma_o <= chroma_rdack_o;
    end
  end
endmodule

// File: tb/tb_mc_ref_rd_arb.sv
// tb_mc_ref_rd_arb: directed vector table plus hand sequences for long bursts, stalls and reset.
module tb_mc_ref_rd_arb;
`ifdef MC_ARB_LUMA_PRIO_EN
  localparam bit P = 1'b1;
`else
  localparam bit P = 1'b0;
`endif
  logic clk = 0, rst;
  logic lr, ll, cr, cl, ma;
  logic [6:0] la, ca;
  logic [7:0] md, rdat, addr;
  logic lg, lk, cg, ck, rd, vl, vc;
  int checks = 0, failures = 0;
  mc_ref_rd_arb #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .luma_req_i(lr), .luma_addr_i(la), .luma_last_i(ll), .luma_gnt_o(lg), .luma_rdack_o(lk),
    .chroma_req_i(cr), .chroma_addr_i(ca), .chroma_last_i(cl), .chroma_gnt_o(cg), .chroma_rdack_o(ck),
    .mem_rden_o(rd), .mem_addr_o(addr), .mem_rdack_i(ma), .mem_data_i(md),
    .rd_data_o(rdat), .rd_valid_luma_o(vl), .rd_valid_chroma_o(vc));
  always #5 clk = ~clk;
  typedef struct {
    logic rst, lr; logic [6:0] la; logic ll, cr; logic [6:0] ca; logic cl, ma; logic [7:0] md;
    logic lg, cg, rd; logic [7:0] addr; logic lk, ck; logic [7:0] rdat; logic vl, vc;
  } vec_t;
  vec_t tbl[10];
  task automatic cyc(input logic r, l_req, input logic [6:0] l_addr, input logic l_last, c_req,
                     input logic [6:0] c_addr, input logic c_last, m_ack, input logic [7:0] m_data);
    @(negedge clk);
    rst = r; lr = l_req; la = l_addr; ll = l_last; cr = c_req; ca = c_addr; cl = c_last; ma = m_ack; md = m_data;
    #1;
  endtask
  task automatic expect_o(input string nm, input logic e_lg, e_cg, e_rd, input logic [7:0] e_addr,
                          input logic e_lk, e_ck, e_vl, e_vc);
    logic [14:0] act, exp_v;
    act   = {lg, cg, rd, addr, lk, ck, vl, vc};
    exp_v = {e_lg, e_cg, e_rd, e_addr, e_lk, e_ck, e_vl, e_vc};
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: {lg,cg,rden,addr,lrdack,crdack,vl,vc} got %b want %b", nm, act, exp_v);
    end
  endtask
  initial begin
    logic pk;
    int stalls;
    tbl[0] = '{1,0,0,0,0,0,0,0,8'h00, 0,0,0,8'h00,0,0,8'h00,0,0};
    tbl[1] = '{0,1,5,1,0,0,0,1,8'h11, 0,0,0,8'h00,0,0,8'h00,0,0};
    tbl[2] = '{0,1,5,1,0,0,0,1,8'h22, 1,0,1,8'h05,1,0,8'h11,0,0};
    tbl[3] = '{0,0,0,0,0,0,0,1,8'h33, 0,0,0,8'h00,0,0,8'h22,1,0};
    tbl[4] = '{0,1,1,1,1,2,1,1,8'h44, 0,0,0,8'h00,0,0,8'h33,0,0};
    tbl[5] = '{0,1,1,1,1,2,1,1,8'h55, P,!P,1,P ? 8'h01 : 8'h82,P,!P,8'h44,0,0};
    tbl[6] = '{0,1,1,1,1,2,1,1,8'h66, !P,P,1,P ? 8'h82 : 8'h01,!P,P,8'h55,P,!P};
    tbl[7] = '{0,0,1,1,0,2,1,1,8'h77, P,!P,0,P ? 8'h01 : 8'h82,0,0,8'h66,!P,P};
    tbl[8] = '{1,0,1,1,0,2,1,1,8'h99, P,!P,0,P ? 8'h01 : 8'h82,0,0,8'h77,0,0};
    tbl[9] = '{0,0,0,0,0,0,0,0,8'hAA, 0,0,0,8'h00,0,0,8'h00,0,0};
    rst = 1; lr = 0; la = 0; ll = 0; cr = 0; ca = 0; cl = 0; ma = 0; md = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].rst, tbl[i].lr, tbl[i].la, tbl[i].ll, tbl[i].cr, tbl[i].ca, tbl[i].cl, tbl[i].ma, tbl[i].md);
      expect_o($sformatf("vec%0d", i), tbl[i].lg, tbl[i].cg, tbl[i].rd, tbl[i].addr,
               tbl[i].lk, tbl[i].ck, tbl[i].vl, tbl[i].vc);
      checks++;
      if (rdat !== tbl[i].rdat) begin
        failures++;
        $display("FAIL vec%0d_rdata: got %h want %h", i, rdat, tbl[i].rdat);
      end
    end
    // 22-row luma burst, chroma waiting from row 2, 3-cycle ack stall on row 5
    cyc(0,1,0,0,0,0,0,1,8'h00);
    expect_o("a_idle",0,0,0,8'h00,0,0,0,0);
    pk = 0;
    for (int r = 0; r < 22; r++) begin
      stalls = (r == 5) ? 3 : 0;
      for (int s = 0; s <= stalls; s++) begin
        cyc(0,1,7'(r),r == 21,r >= 2,3,1,s == stalls,8'(r));
        expect_o($sformatf("a_row%0d_s%0d", r, s),1,0,1,{1'b0,7'(r)},s == stalls,0,pk,0);
        pk = (s == stalls);
      end
    end
    cyc(0,0,0,0,1,3,1,1,8'h00);
    expect_o("a_chroma",0,1,1,8'h83,0,1,1,0);
    cyc(0,0,0,0,0,0,0,0,8'h00);
    expect_o("a_done",0,0,0,8'h00,0,0,0,1);
    // single-row luma burst leaves luma as last owner, then simultaneous requests
    cyc(0,1,9,1,0,0,0,1,8'h00);
    expect_o("b_idle",0,0,0,8'h00,0,0,0,0);
    cyc(0,1,9,1,0,0,0,1,8'h00);
    expect_o("b_luma",1,0,1,8'h09,1,0,0,0);
    cyc(0,1,4,1,1,6,1,0,8'h00);
    expect_o("b_both_idle",0,0,0,8'h00,0,0,1,0);
    cyc(0,1,4,1,1,6,1,0,8'h00);
    expect_o("b_winner",P,!P,1,P ? 8'h04 : 8'h86,0,0,0,0);
    // reset at row 7 of a luma burst
    cyc(1,0,0,0,0,0,0,0,8'h00);
    cyc(0,1,0,0,0,0,0,1,8'h00);
    expect_o("c_idle",0,0,0,8'h00,0,0,0,0);
    pk = 0;
    for (int r = 0; r < 7; r++) begin
      cyc(0,1,7'(r),0,0,0,0,1,8'h00);
      expect_o($sformatf("c_row%0d", r),1,0,1,{1'b0,7'(r)},1,0,pk,0);
      pk = 1;
    end
    cyc(1,1,7,0,0,0,0,1,8'h00);
    expect_o("c_row7_rst",1,0,1,8'h07,1,0,1,0);
    cyc(0,1,2,1,1,3,1,1,8'h00);
    expect_o("c_after_rst",0,0,0,8'h00,0,0,0,0);
    cyc(0,1,2,1,1,3,1,1,8'h00);
    expect_o("c_luma_first",1,0,1,8'h02,1,0,0,0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
